// File: rtl/core_op_issuer.sv
// core_op_issuer: command sequencer that issues op modes and streams pixels into the image-processing core
module core_op_issuer #(
  parameter int INST_BW      = 4,
  parameter int INPUT_BW     = 8,
  parameter int IMG_SIZE     = 2048,
  parameter int LOAD_TIMEOUT = 3000,
  parameter int CNT_BW       = 12
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  input  logic [INST_BW-1:0]  i_cmd_mode,
  output logic                o_cmd_ready,
  input  logic                i_pix_valid,
  input  logic [INPUT_BW-1:0] i_pix_data,
  output logic                o_pix_ready,
  input  logic                i_op_ready,
  output logic                o_op_valid,
  output logic [INST_BW-1:0]  o_op_mode,
  input  logic                i_in_ready,
  output logic                o_in_valid,
  output logic [INPUT_BW-1:0] o_in_data,
  input  logic                i_out_valid,
  output logic                o_busy,
  output logic                o_done,
  output logic [5:0]          o_depth,
  output logic                o_err
);
  typedef enum logic [2:0] {IDLE, WAIT_RDY, ISSUE, LOAD, COLLECT, DONE} state_t;
  localparam logic [INST_BW-1:0] M_LOAD = INST_BW'(0);
  localparam logic [INST_BW-1:0] M_SCAD = INST_BW'(5);
  localparam logic [INST_BW-1:0] M_SCAU = INST_BW'(6);
  localparam logic [INST_BW-1:0] M_DISP = INST_BW'(7);
  localparam logic [INST_BW-1:0] M_CONV = INST_BW'(8);
  localparam logic [INST_BW-1:0] M_MEDF = INST_BW'(9);
  localparam logic [INST_BW-1:0] M_DHWT = INST_BW'(10);
  state_t              state;
  logic                rdy_flag;
  logic                op_valid_r;
  logic                in_load;
  logic                pix_fire;
  logic [INST_BW-1:0]  mode;
  logic [CNT_BW-1:0]   pix_cnt;
  logic [CNT_BW-1:0]   out_cnt;
  logic [CNT_BW-1:0]   tmo_cnt;
  logic [CNT_BW-1:0]   exp_cnt;
  logic [CNT_BW-1:0]   nxt_exp;
  logic [5:0]          nxt_depth;
  // the reset cycle must never present a handshake to the core
  assign in_load     = state == LOAD && !i_rst;
  assign o_in_valid  = in_load && i_pix_valid;
  assign o_in_data   = o_in_valid ? i_pix_data : '0;
  assign o_pix_ready = in_load && i_in_ready;
  assign o_cmd_ready = state == IDLE && !i_rst;
  assign o_op_valid  = op_valid_r && !i_rst;
  assign o_busy      = state != IDLE;
  assign pix_fire    = o_in_valid && i_in_ready;
  always_comb begin
    nxt_depth = mode == M_SCAD ? (o_depth == 6'd32 ? 6'd16 : 6'd8) :
                mode == M_SCAU ? (o_depth == 6'd8 ? 6'd16 : 6'd32) :
                mode == M_LOAD ? 6'd32 : o_depth;
    nxt_exp   = mode == M_CONV ? CNT_BW'(4) :
                mode == M_DISP ? CNT_BW'({nxt_depth, 2'b00}) :
                (mode == M_MEDF || mode == M_DHWT) ? CNT_BW'(16) : '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      rdy_flag   <= 1'b0;
      op_valid_r <= 1'b0;
      o_op_mode  <= '0;
      mode       <= '0;
      pix_cnt    <= '0;
      out_cnt    <= '0;
      tmo_cnt    <= '0;
      exp_cnt    <= '0;
      o_done     <= 1'b0;
      o_depth    <= 6'd32;
      o_err      <= 1'b0;
    end else begin
      op_valid_r <= 1'b0;
      o_op_mode  <= '0;
      o_done     <= 1'b0;
      rdy_flag   <= state == ISSUE ? 1'b0 : rdy_flag | i_op_ready;
      if (((state == LOAD || state == ISSUE) && i_op_ready) || (state != COLLECT && i_out_valid))
        o_err <= 1'b1;
      case (state)
        IDLE: if (i_cmd_valid) begin
          if (i_cmd_mode > M_DHWT) o_err <= 1'b1;
          else begin
            mode  <= i_cmd_mode;
            state <= WAIT_RDY;
          end
        end
        WAIT_RDY: if (rdy_flag || i_op_ready) begin
          op_valid_r <= 1'b1;
          o_op_mode  <= mode;
          state      <= ISSUE;
        end
        ISSUE: begin
          o_depth <= nxt_depth;
          exp_cnt <= nxt_exp;
          pix_cnt <= '0;
          out_cnt <= '0;
          tmo_cnt <= '0;
          o_done  <= mode != M_LOAD && nxt_exp == '0;
          state   <= mode == M_LOAD ? LOAD : nxt_exp != '0 ? COLLECT : DONE;
        end
        LOAD: begin
          if (!(&tmo_cnt)) tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_cnt > CNT_BW'(LOAD_TIMEOUT)) o_err <= 1'b1;
          if (pix_fire) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == CNT_BW'(IMG_SIZE - 1)) begin
              o_done <= 1'b1;
              state  <= DONE;
            end
          end
        end
        COLLECT: if (i_out_valid) begin
          out_cnt <= out_cnt + 1'b1;
          if (out_cnt == exp_cnt - 1'b1) begin
            o_done <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_core_op_issuer.sv
// tb_core_op_issuer: randomized self-checking bench for core_op_issuer against a behavioural op model
module tb_core_op_issuer;
  localparam int IMG = 2048;
  localparam int TMO = 3000;
  logic       i_clk = 0, i_rst = 1;
  logic       i_cmd_valid = 0, i_pix_valid = 0, i_op_ready = 0, i_in_ready = 0, i_out_valid = 0;
  logic [3:0] i_cmd_mode = 0;
  logic [7:0] i_pix_data = 0;
  logic       o_cmd_ready, o_pix_ready, o_op_valid, o_in_valid, o_busy, o_done, o_err;
  logic [3:0] o_op_mode;
  logic [7:0] o_in_data;
  logic [5:0] o_depth;
  int checks = 0, errors = 0;
  int op_cnt = 0, done_cnt = 0, xfer = 0, data_bad = 0;
  int model_depth = 32;
  bit model_err = 0;
  logic [7:0] pixq[$];
  core_op_issuer dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .i_cmd_mode(i_cmd_mode), .o_cmd_ready(o_cmd_ready),
    .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready),
    .i_op_ready(i_op_ready), .o_op_valid(o_op_valid), .o_op_mode(o_op_mode),
    .i_in_ready(i_in_ready), .o_in_valid(o_in_valid), .o_in_data(o_in_data),
    .i_out_valid(i_out_valid), .o_busy(o_busy), .o_done(o_done),
    .o_depth(o_depth), .o_err(o_err)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int depth_after(input int m, input int d);
    if (m == 0) return 32;
    if (m == 5) return (d / 2 < 8) ? 8 : d / 2;
    if (m == 6) return (d * 2 > 32) ? 32 : d * 2;
    return d;
  endfunction
  function automatic int outs_for(input int m, input int d);
    if (m == 8) return 4;
    if (m == 7) return 4 * d;
    if (m == 9 || m == 10) return 16;
    return 0;
  endfunction
  // core-side observer: counts pulses and transfers, checks pass-through and hold-while-stalled
  initial begin
    logic [7:0] held, want;
    bit hold_pend;
    hold_pend = 0;
    held = 0;
    forever begin
      @(negedge i_clk);
      if (o_op_valid) op_cnt++;
      if (o_done) done_cnt++;
      if (o_in_valid) begin
        if (o_in_data !== i_pix_data || !i_pix_valid) data_bad++;
        if (hold_pend && o_in_data !== held) data_bad++;
      end else if (hold_pend) data_bad++;
      hold_pend = 0;
      if (o_in_valid && i_in_ready) begin
        xfer++;
        if (pixq.size() == 0) data_bad++;
        else begin
          want = pixq.pop_front();
          if (want !== o_in_data) data_bad++;
        end
      end else if (o_in_valid) begin
        hold_pend = 1;
        held = o_in_data;
      end
    end
  end
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic send_cmd(input int m);
    int n;
    n = 0;
    i_cmd_valid = 1;
    i_cmd_mode = 4'(m);
    #1;
    while (!o_cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("cmd_ready_bound", 0, 1);
    tick();
    i_cmd_valid = 0;
  endtask
  task automatic load_pixels(input int n, input bit toggle, output int cyc);
    int sent;
    bit fire;
    sent = 0;
    cyc = 0;
    while (sent < n && cyc < 20000) begin
      i_in_ready = toggle ? cyc[0] : 1'b1;
      if (!i_pix_valid && $urandom_range(0, 7) != 0) begin
        i_pix_valid = 1;
        i_pix_data = 8'($urandom);
        pixq.push_back(i_pix_data);
      end
      #1;
      fire = i_pix_valid && o_pix_ready;
      tick();
      cyc++;
      if (fire) begin
        sent++;
        i_pix_valid = 0;
      end
    end
    if (sent < n) check("load_bound", sent, n);
    i_in_ready = 0;
  endtask
  task automatic send_outs(input int e);
    int s, cyc;
    s = 0;
    cyc = 0;
    while (s < e && cyc < 2000) begin
      i_out_valid = $urandom_range(0, 3) != 0;
      tick();
      cyc++;
      if (i_out_valid) s++;
    end
    i_out_valid = 0;
    if (s < e) check("outs_bound", s, e);
  endtask
  task automatic run_op(input int m, input bit early, input bit toggle, input bit extra);
    int ops0, done0, x0, e, cyc;
    ops0 = op_cnt;
    done0 = done_cnt;
    x0 = xfer;
    if (early) begin
      i_op_ready = 1;
      tick();
      i_op_ready = 0;
      repeat (5) tick();
      check("idle_busy", o_busy, 0);
    end
    send_cmd(m);
    check("wait_busy", o_busy, 1);
    check("cmd_ready_busy", o_cmd_ready, 0);
    if (!early) i_op_ready = 1;
    tick();
    i_op_ready = 0;
    check("op_valid", o_op_valid, 1);
    check("op_mode", o_op_mode, m);
    model_depth = depth_after(m, model_depth);
    e = outs_for(m, model_depth);
    tick();
    check("op_valid_once", o_op_valid, 0);
    check("depth", o_depth, model_depth);
    if (m == 0) begin
      load_pixels(IMG, toggle, cyc);
      if (cyc > TMO) model_err = 1;
      check("xfers", xfer - x0, IMG);
    end else if (e > 0) send_outs(e);
    check("done", o_done, 1);
    if (extra) begin
      i_out_valid = 1;
      model_err = 1;
    end
    tick();
    i_out_valid = 0;
    check("op_pulses", op_cnt - ops0, 1);
    check("done_pulses", done_cnt - done0, 1);
    check("busy_end", o_busy, 0);
    check("err", o_err, model_err);
  endtask
  initial begin
    int cyc, ops0, x0;
    repeat (3) tick();
    check("rst_depth", o_depth, 32);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    check("rst_done", o_done, 0);
    check("rst_op_valid", o_op_valid, 0);
    check("rst_in_valid", o_in_valid, 0);
    i_rst = 0;
    #1;
    check("idle_cmd_ready", o_cmd_ready, 1);
    run_op(0, 1, 0, 0);
    run_op(5, 0, 0, 0);
    run_op(5, 0, 0, 0);
    run_op(5, 0, 0, 0);
    run_op(7, 0, 0, 0);
    run_op(6, 0, 0, 0);
    run_op(6, 0, 0, 0);
    run_op(6, 0, 0, 0);
    run_op(8, 0, 0, 0);
    run_op(9, 1, 0, 0);
    repeat (10) run_op($urandom_range(1, 10), 1'($urandom_range(0, 1)), 0, 0);
    run_op(8, 0, 0, 1);
    i_rst = 1;
    tick();
    i_rst = 0;
    model_err = 0;
    model_depth = 32;
    check("rst_clears_err", o_err, 0);
    run_op(5, 0, 0, 0);
    run_op(0, 0, 1, 0);
    check("timeout_err", o_err, 1);
    send_cmd(0);
    i_op_ready = 1;
    tick();
    i_op_ready = 0;
    tick();
    x0 = xfer;
    load_pixels(100, 0, cyc);
    check("partial_xfers", xfer - x0, 100);
    i_pix_valid = 1;
    i_pix_data = 8'hA5;
    i_in_ready = 1;
    i_rst = 1;
    #1;
    check("rst_cycle_in_valid", o_in_valid, 0);
    check("rst_cycle_pix_ready", o_pix_ready, 0);
    check("rst_cycle_op_valid", o_op_valid, 0);
    tick();
    i_rst = 0;
    i_pix_valid = 0;
    pixq.delete();
    check("abort_busy", o_busy, 0);
    check("abort_depth", o_depth, 32);
    check("abort_in_valid", o_in_valid, 0);
    check("abort_err", o_err, 0);
    ops0 = op_cnt;
    send_cmd(11);
    check("illegal_err", o_err, 1);
    check("illegal_busy", o_busy, 0);
    repeat (3) tick();
    check("illegal_no_op", op_cnt - ops0, 0);
    check("illegal_cmd_ready", o_cmd_ready, 1);
    check("data", data_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
